// File: rtl/act_pwl_pipe.sv
// rtl/act_pwl_pipe.sv - three-stage piecewise-linear tanh/sigmoid activation pipeline
//
// Purpose: approximates tanh (in_mode=0) or sigmoid (in_mode=1) on signed
// fixed-point samples with a 4-segment piecewise-linear curve. Stages:
//   S1 pre-scale (sigmoid halves X), absolute value, segment select
//   S2 segment arithmetic on the magnitude
//   S3 sign restore and sigmoid offset, into the output register
// All stages advance together whenever the output register can move, so
// in_ready is a pure function of out_ready and out_valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  input sample handshake, signed X
//   in_mode                    0 = tanh, 1 = sigmoid, travels with the sample
//   out_valid/out_ready/out_data  output handshake, signed Y
//   sat_clr, sat_cnt           saturation counter clear / count
//
// Configuration: define ACT_PWL_SAT_CNT_EN to build the saturation counter;
// otherwise sat_cnt is tied to zero and sat_clr is ignored.

module act_pwl_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  sat_clr,
  output logic [CNT_WIDTH-1:0]  sat_cnt
);

  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1) << FRACT_WIDTH;
  localparam logic [DATA_WIDTH-1:0] HALF    = ONE >> 1;
  localparam logic [DATA_WIDTH-1:0] QTR     = ONE >> 2;
  localparam logic [DATA_WIDTH-1:0] TWO     = ONE << 1;
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic w_adv;

  // Stage 1 state
  logic                  r1_valid;
  logic [DATA_WIDTH-1:0] r1_abs;
  logic                  r1_neg;
  logic                  r1_mode;
  logic [1:0]            r1_seg;

  // Stage 2 state
  logic                  r2_valid;
  logic [DATA_WIDTH-1:0] r2_t;
  logic                  r2_neg;
  logic                  r2_mode;
  logic                  r2_sat;

  // Output register
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_sat;

  // Stage 1 combinational
  logic [DATA_WIDTH-1:0] w_xs;
  logic                  w_neg;
  logic [DATA_WIDTH-1:0] w_abs;
  logic [1:0]            w_seg;

  // Stage 2 / 3 combinational
  logic [DATA_WIDTH-1:0] w_t;
  logic [DATA_WIDTH:0]   w_t_ext;
  logic [DATA_WIDTH:0]   w_tsgn;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_y;

  assign w_adv     = out_ready | ~r_out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_comb begin
    w_xs  = in_mode ? {in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-1:1]} : in_data;
    w_neg = w_xs[DATA_WIDTH-1];
    // The most-negative value has no positive twin; clamp to the largest positive.
    if (!w_neg)              w_abs = w_xs;
    else if (w_xs == MIN_NEG) w_abs = MAX_POS;
    else                     w_abs = -w_xs;
    if (w_abs < HALF)      w_seg = 2'd0;
    else if (w_abs < ONE)  w_seg = 2'd1;
    else if (w_abs < TWO)  w_seg = 2'd2;
    else                   w_seg = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_abs   <= '0;
      r1_neg   <= 1'b0;
      r1_mode  <= 1'b0;
      r1_seg   <= 2'd0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_abs   <= w_abs;
      r1_neg   <= w_neg;
      r1_mode  <= in_mode;
      r1_seg   <= w_seg;
    end
  end

  always_comb begin
    w_t = ONE;
    case (r1_seg)
      2'd0:    w_t = r1_abs;
      2'd1:    w_t = (r1_abs >> 1) + QTR;
      2'd2:    w_t = (r1_abs >> 2) + HALF;
      default: w_t = ONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_t     <= '0;
      r2_neg   <= 1'b0;
      r2_mode  <= 1'b0;
      r2_sat   <= 1'b0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_t     <= w_t;
      r2_neg   <= r1_neg;
      r2_mode  <= r1_mode;
      r2_sat   <= (r1_seg == 2'd3);
    end
  end

  // One extra bit keeps T + ONE from overflowing before the sigmoid halving.
  always_comb begin
    w_t_ext = {1'b0, r2_t};
    w_tsgn  = r2_neg ? -w_t_ext : w_t_ext;
    w_sum   = w_tsgn + {1'b0, ONE};
    w_y     = r2_mode ? w_sum[DATA_WIDTH:1] : w_tsgn[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_out_data <= w_y;
        r_out_sat  <= r2_sat;
      end
    end
  end

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, w_sum[0], w_tsgn[DATA_WIDTH]};

`ifdef ACT_PWL_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] r_sat_cnt;

  // Clear has priority over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_sat && !(&r_sat_cnt)) begin
      r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat = &{1'b0, sat_clr, r_out_sat};
  assign sat_cnt      = '0;
`endif

endmodule
